// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// taken-branch squashes, data-memory wait freeze with watchdog, and perf counters.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned ZERO_REG = 31,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mem_branch,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic [1:0]       ctrl_state,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [WAIT_W-1:0]   wait_cnt, wait_nx;
   logic                id_v, ex_v, mem_v;
   logic                ldu_c, br_c, freeze_c, decode_c, br_take_c;

   // Valid-qualified hazard decode
   assign ldu_c = ex_v & id_v & ex_memread & (ex_rd != REG_W'(ZERO_REG)) &
                  ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
   assign br_c  = mem_v & mem_branch;

   assign ctrl_state = state;

   // Next-state and pipeline control; priority FAULT > busy > branch > load-use
   always_comb begin
      state_nx     = state;
      wait_nx      = wait_cnt;
      freeze_c     = 1'b0;
      decode_c     = 1'b0;
      br_take_c    = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;

      if (reset) begin
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (dmem_busy) begin
                  freeze_c = 1'b1;
                  state_nx = ST_WAIT;
                  wait_nx  = WAIT_W'(1);
               end else begin
                  decode_c = 1'b1;
               end
            end
            ST_WAIT: begin
               if (dmem_busy) begin
                  freeze_c = 1'b1;
                  wait_nx  = wait_cnt + WAIT_W'(1);
                  if (wait_nx == WAIT_W'(MAX_WAIT)) state_nx = ST_FAULT;
               end else begin
                  decode_c = 1'b1;
                  state_nx = ST_RUN;
                  wait_nx  = '0;
               end
            end
            ST_FAULT: freeze_c = 1'b1;
            default:  state_nx = ST_RUN;
         endcase

         if (freeze_c) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
         end else if (decode_c) begin
            if (br_c) begin
               br_take_c   = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               exmem_flush = 1'b1;
            end else if (ldu_c) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
         end
      end
   end

   // State, valid bits, watchdog and saturating counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         wait_cnt  <= '0;
         id_v      <= 1'b0;
         ex_v      <= 1'b0;
         mem_v     <= 1'b0;
         fault     <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         id_v     <= ifid_flush  ? 1'b0 : (ifid_write  ? 1'b1 : id_v);
         ex_v     <= idex_bubble ? 1'b0 : (idex_write  ? id_v : ex_v);
         mem_v    <= exmem_flush ? 1'b0 : (exmem_write ? ex_v : mem_v);
         fault    <= fault | (state_nx == ST_FAULT);
         if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (br_take_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch squash, memory wait,
// watchdog fault, reset recovery and counter saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rn, id_rm, ex_rd;
   logic        id_uses_rn, id_uses_rm, ex_memread, mem_branch, dmem_busy;
   logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
   logic        exmem_write, exmem_flush, memwb_bubble, fault;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch(mem_branch), .dmem_busy(dmem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
      .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .ctrl_state(ctrl_state),
      .fault(fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
      id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_memread = 1'b0;
      mem_branch = 1'b0; dmem_busy = 1'b0;
   endtask

   task automatic refill();
      clr_in();
      repeat (3) tick();
   endtask

   initial begin
      reset = 1'b1;
      clr_in();
      tick(); tick();
      #1;
      chk("rst_pc_write", 32'(pc_write), 32'd1);
      chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("rst_memwb_bubble", 32'(memwb_bubble), 32'd1);
      chk("rst_state", 32'(ctrl_state), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      reset = 1'b0;
      refill();
      #1;
      chk("idle_pc_write", 32'(pc_write), 32'd1);
      chk("idle_idex_bubble", 32'(idex_bubble), 32'd0);

      // Load-use on Rn
      ex_memread = 1'b1; ex_rd = 5'd1; id_rn = 5'd1; id_uses_rn = 1'b1;
      #1;
      chk("ldu_pc_write", 32'(pc_write), 32'd0);
      chk("ldu_ifid_write", 32'(ifid_write), 32'd0);
      chk("ldu_idex_bubble", 32'(idex_bubble), 32'd1);
      chk("ldu_idex_write", 32'(idex_write), 32'd1);
      tick();
      #1;
      chk("ldu_once_pc_write", 32'(pc_write), 32'd1);
      chk("ldu_once_bubble", 32'(idex_bubble), 32'd0);
      chk("ldu_stall_cnt", 32'(stall_cnt), 32'd1);
      refill();

      // Zero register and unused-operand cases, then a real Rm hazard
      ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1;
      #1;
      chk("xzr_no_stall", 32'(pc_write), 32'd1);
      id_uses_rn = 1'b0; ex_rd = 5'd5; id_rm = 5'd5; id_uses_rm = 1'b0;
      #1;
      chk("rm_unused_no_stall", 32'(pc_write), 32'd1);
      id_uses_rm = 1'b1;
      #1;
      chk("rm_stall", 32'(pc_write), 32'd0);
      tick();
      #1;
      chk("rm_stall_cnt", 32'(stall_cnt), 32'd2);
      refill();

      // Taken branch
      mem_branch = 1'b1;
      #1;
      chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("br_idex_bubble", 32'(idex_bubble), 32'd1);
      chk("br_exmem_flush", 32'(exmem_flush), 32'd1);
      chk("br_pc_write", 32'(pc_write), 32'd1);
      chk("br_memwb_bubble", 32'(memwb_bubble), 32'd0);
      tick();
      #1;
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br_squashed_no_flush", 32'(ifid_flush), 32'd0);
      mem_branch = 1'b0;
      ex_memread = 1'b1; ex_rd = 5'd1; id_rn = 5'd1; id_uses_rn = 1'b1;
      #1;
      chk("br_squashed_no_ldu", 32'(pc_write), 32'd1);
      refill();

      // Load-use and branch together: branch wins
      ex_memread = 1'b1; ex_rd = 5'd1; id_rn = 5'd1; id_uses_rn = 1'b1; mem_branch = 1'b1;
      #1;
      chk("brldu_pc_write", 32'(pc_write), 32'd1);
      chk("brldu_ifid_write", 32'(ifid_write), 32'd1);
      chk("brldu_ifid_flush", 32'(ifid_flush), 32'd1);
      tick();
      #1;
      chk("brldu_stall_cnt", 32'(stall_cnt), 32'd2);
      chk("brldu_flush_cnt", 32'(flush_cnt), 32'd2);
      refill();

      // Memory busy for 4 cycles, branch ignored while busy, honoured on release
      dmem_busy = 1'b1; mem_branch = 1'b1;
      #1;
      chk("busy_pc_write", 32'(pc_write), 32'd0);
      chk("busy_exmem_write", 32'(exmem_write), 32'd0);
      chk("busy_memwb_bubble", 32'(memwb_bubble), 32'd1);
      chk("busy_br_ignored", 32'(ifid_flush), 32'd0);
      mem_branch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("wait_state", 32'(ctrl_state), 32'd1);
         chk("wait_pc_write", 32'(pc_write), 32'd0);
      end
      tick();
      dmem_busy = 1'b0; mem_branch = 1'b1;
      #1;
      chk("wait_exit_pc_write", 32'(pc_write), 32'd1);
      chk("wait_exit_memwb", 32'(memwb_bubble), 32'd0);
      chk("wait_exit_br", 32'(ifid_flush), 32'd1);
      tick();
      #1;
      chk("wait_back_run", 32'(ctrl_state), 32'd0);
      chk("wait_stall_cnt", 32'(stall_cnt), 32'd6);
      chk("wait_flush_cnt", 32'(flush_cnt), 32'd3);
      refill();

      // Reset in the middle of WAIT
      dmem_busy = 1'b1;
      tick();
      #1;
      chk("pre_rst_wait", 32'(ctrl_state), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_in_wait_pc_write", 32'(pc_write), 32'd1);
      tick();
      reset = 1'b0; dmem_busy = 1'b0;
      #1;
      chk("rst_wait_state", 32'(ctrl_state), 32'd0);
      chk("rst_wait_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_wait_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_wait_pc_write", 32'(pc_write), 32'd1);
      tick();

      // Watchdog: 15 busy cycles reach FAULT
      dmem_busy = 1'b1;
      repeat (14) tick();
      #1;
      chk("wd_14_state", 32'(ctrl_state), 32'd1);
      chk("wd_14_fault", 32'(fault), 32'd0);
      tick();
      #1;
      chk("wd_15_state", 32'(ctrl_state), 32'd2);
      chk("wd_15_fault", 32'(fault), 32'd1);
      chk("wd_15_stall_cnt", 32'(stall_cnt), 32'd15);
      dmem_busy = 1'b0;
      #1;
      chk("fault_pc_write", 32'(pc_write), 32'd0);
      chk("fault_memwb_bubble", 32'(memwb_bubble), 32'd1);
      tick();
      #1;
      chk("fault_sticky_state", 32'(ctrl_state), 32'd2);
      chk("fault_sticky", 32'(fault), 32'd1);

      // Counter saturation while held in FAULT
      repeat (70000) tick();
      #1;
      chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
      chk("fault_after_long", 32'(fault), 32'd1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("fault_cleared", 32'(fault), 32'd0);
      chk("fault_rst_state", 32'(ctrl_state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
